// File: rtl/inertial_delay_pkg.sv
// Shared state encoding, defaults and sizing helper for the inertial-delay filter.
package inertial_delay_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    localparam int DEF_DELAY_CYC = 5;
    localparam int DEF_CNT_W     = 8;

    // Stability counter must hold values 0..DELAY_CYC-1 plus headroom for the +1 path.
    function automatic int stab_cnt_width(input int delay_cyc);
        return $clog2(delay_cyc + 1);
    endfunction

endpackage

// File: rtl/inertial_delay_filter_sat_counter.sv
// Saturating up-counter: synchronous clear has priority, increments stop at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/inertial_delay_filter.sv
// Inertial-delay deglitcher: a level change reaches out only after DELAY_CYC identical samples.
// GLITCH_COUNT_EN adds a saturating glitch_cnt output counting rejected pulses.
module inertial_delay_filter
    import inertial_delay_pkg::*;
#(
    parameter int DELAY_CYC = DEF_DELAY_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    output logic             out,
    output logic             busy,
    output logic             glitch_pulse
`ifdef GLITCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] glitch_cnt
`endif
);

    localparam int            SW       = stab_cnt_width(DELAY_CYC);
    localparam logic [SW-1:0] CNT_LAST = SW'(DELAY_CYC - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          glitch_q, glitch_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        glitch_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (a != out_q) begin
                    // With a one-sample window the first sample already qualifies.
                    if (DELAY_CYC == 1) begin
                        out_d = a;
                    end else begin
                        state_d = ST_PEND;
                        cnt_d   = SW'(1);
                    end
                end
            end
            ST_PEND: begin
                if (a == out_q) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    out_d   = a;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            glitch_q <= glitch_d;
        end
    end

    assign out          = out_q;
    assign busy         = (state_q == ST_PEND);
    assign glitch_pulse = glitch_q;

`ifdef GLITCH_COUNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_glitch_cnt (
        .clk  (clk),
        .clr_i(rst),
        .inc_i(glitch_q),
        .cnt_o(glitch_cnt)
    );
`endif

endmodule
